fifo_hash_unit: RTL and testbench

Packet-path helper that pairs a small first-word-fall-through (FWFT) FIFO with an independent two-output combinational hash. The FIFO sits between an upstream producer and a header-parsing state machine and provides `in_rdy`-style backpressure. The hash turns a flow tuple (IPs, ports, sequence/ack number) into two table indices for a Bloom-filter style lookup. The two halves share only `clk`/`reset`.

---
 rtl/fifo_hash_unit_if.sv | 33 +++
 rtl/fifo_hash_unit.sv | 114 +++++++++++
 tb/tb_fifo_hash_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fifo_hash_unit_if.sv
// Handshake bundle for the FWFT FIFO half of fifo_hash_unit.
// The producer/consumer side is the master and the FIFO is the slave.
interface fifo_hash_unit_if #(
    parameter int WIDTH = 72
);
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             empty;

    modport master (
        output din,
        output wr_en,
        output rd_en,
        input  dout,
        input  full,
        input  nearly_full,
        input  empty
    );

    modport slave (
        input  din,
        input  wr_en,
        input  rd_en,
        output dout,
        output full,
        output nearly_full,
        output empty
    );
endinterface

// File: rtl/fifo_hash_unit.sv
// Small first-word-fall-through FIFO plus an independent two-index
// combinational flow hash used for Bloom-filter style lookups.
module fifo_hash_unit #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3,
    parameter int INPUT_WIDTH    = 128,
    parameter int OUTPUT_WIDTH   = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    fifo_hash_unit_if.slave         fif,
    input  logic [INPUT_WIDTH-1:0]  data,
    output logic [OUTPUT_WIDTH-1:0] hash_0,
    output logic [OUTPUT_WIDTH-1:0] hash_1
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int NCH   = (INPUT_WIDTH + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH;
    localparam int PW    = MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;

    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_NF  = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             nf_q, nf_d;
    logic             empty_q, empty_d;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = fif.wr_en & ~full_q;
    assign rd_ok = fif.rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end
        full_d  = (count_d == CNT_MAX);
        nf_d    = (count_d >= CNT_NF);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            nf_q     <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            nf_q     <= nf_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is deliberately not cleared on reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q] <= fif.din;
        end
    end

    assign fif.dout        = mem_q[rd_ptr_q];
    assign fif.full        = full_q;
    assign fif.nearly_full = nf_q;
    assign fif.empty       = empty_q;

    function automatic logic [OUTPUT_WIDTH-1:0] rotl(
        input logic [OUTPUT_WIDTH-1:0] v,
        input int                      r
    );
        rotl = (v << r) | (v >> (OUTPUT_WIDTH - r));
    endfunction

    logic [NCH*OUTPUT_WIDTH-1:0] pad_data;
    logic [OUTPUT_WIDTH-1:0]     chunk;

    // Last chunk is zero-extended; chunk k feeds hash_1 rotated by k.
    always_comb begin
        pad_data = '0;
        pad_data[INPUT_WIDTH-1:0] = data;
        hash_0 = '0;
        hash_1 = '0;
        chunk  = '0;
        for (int k = 0; k < NCH; k++) begin
            chunk  = pad_data[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            hash_0 = hash_0 ^ chunk;
            hash_1 = hash_1 ^ rotl(chunk, k % OUTPUT_WIDTH);
        end
    end

endmodule

// File: tb/tb_fifo_hash_unit.sv
// Self-checking bench for fifo_hash_unit: FIFO scoreboard sequences
// plus a table of hash vectors.
module tb_fifo_hash_unit;

    logic         clk;
    logic         reset;
    logic [127:0] data;
    logic [18:0]  hash_0;
    logic [18:0]  hash_1;

    fifo_hash_unit_if #(.WIDTH(72)) fif ();

    fifo_hash_unit #(
        .WIDTH(72),
        .MAX_DEPTH_BITS(3),
        .INPUT_WIDTH(128),
        .OUTPUT_WIDTH(19)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fif(fif),
        .data(data),
        .hash_0(hash_0),
        .hash_1(hash_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [71:0] q[$];

    typedef struct {
        logic [127:0] data;
        logic [18:0]  h0;
        logic [18:0]  h1;
    } hvec_t;

    hvec_t hv[6];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_flags(input string nm);
        int c;
        c = q.size();
        chk({nm, "_empty"}, 128'(fif.empty), 128'(c == 0));
        chk({nm, "_full"}, 128'(fif.full), 128'(c == 8));
        chk({nm, "_nf"}, 128'(fif.nearly_full), 128'(c >= 7));
        if (c > 0) chk({nm, "_head"}, 128'(fif.dout), 128'(q[0]));
    endtask

    // One clock cycle; called and returns at posedge+1.
    task automatic cyc(input logic w, input logic r, input logic [71:0] d);
        int          c0;
        logic [71:0] e;
        fif.wr_en = w;
        fif.rd_en = r;
        fif.din   = d;
        #1;
        c0 = q.size();
        if (r && c0 > 0) begin
            e = q.pop_front();
            chk("dout_pop", 128'(fif.dout), 128'(e));
        end
        if (w && c0 < 8) q.push_back(d);
        @(posedge clk);
        #1;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
        chk_flags("post");
    endtask

    initial begin
        hv[0] = '{128'd0, 19'd0, 19'd0};
        hv[1] = '{128'd1, 19'd1, 19'd1};
        hv[2] = '{128'd1 << 19, 19'd1, 19'd2};
        hv[3] = '{(128'd1 << 19) | 128'd1, 19'd0, 19'd3};
        hv[4] = '{{128{1'b1}}, 19'h03FFF, 19'h7FFC1};
        hv[5] = '{128'd1 << 114, 19'd1, 19'h40};

        reset     = 1'b1;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
        fif.din   = '0;
        data      = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_flags("reset");

        for (int i = 0; i < 6; i++) begin
            data = hv[i].data;
            #1;
            chk($sformatf("hash0_v%0d", i), 128'(hash_0), 128'(hv[i].h0));
            chk($sformatf("hash1_v%0d", i), 128'(hash_1), 128'(hv[i].h1));
        end

        // Single word fall-through then pop.
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 72'hAA);
        chk("aa_visible", 128'(fif.dout), 128'h0AA);
        cyc(1'b0, 1'b1, '0);

        // Fill to full, overflow write dropped, drain in order.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 72'(i));
        cyc(1'b1, 1'b0, 72'h99);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, '0);
        chk("drained_empty", 128'(fif.empty), 128'd1);

        // Fill, then simultaneous read/write across pointer wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 72'(16'h100 + i));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 72'(16'h200 + i));
        while (q.size() > 0) cyc(1'b0, 1'b1, '0);

        // Read+write on empty: read ignored, write lands.
        cyc(1'b1, 1'b1, 72'h55);
        chk("rw_empty_dout", 128'(fif.dout), 128'h55);
        chk("rw_empty_cnt1", 128'(fif.empty), 128'd0);
        cyc(1'b0, 1'b1, '0);

        // Reset with 5 words stored and a write pending.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 72'(16'h300 + i));
        reset     = 1'b1;
        fif.wr_en = 1'b1;
        fif.din   = 72'h77;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        fif.wr_en = 1'b0;
        q.delete();
        chk_flags("midreset");
        cyc(1'b1, 1'b0, 72'h66);
        cyc(1'b0, 1'b1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
